// File: rtl/divisor_restador_4bit_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package paquete_divisor;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/paso_division.sv
// One combinational iteration of the restoring divider: shift {rem,quo} left,
// attempt rem - B at WIDTH+1 bits, keep the difference only if it did not borrow.
import paquete_divisor::*;

module paso_division #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next,
  output logic             borrow
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // The remainder never exceeds B-1, so the top bit shifted out of rem is always zero.
  assign rem_sh   = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, B};
  assign borrow   = trial[WIDTH];
  assign rem_next = borrow ? rem_sh : trial;
  assign quo_next = (quo << 1) | {{(WIDTH-1){1'b0}}, ~borrow};

endmodule

// File: rtl/divisor_restador_4bit.sv
// Sequential restoring divider: unsigned A / B over WIDTH iterations, one per clock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; operands sampled on the accepting edge
// ST_CALC | one shift/trial-subtract per edge, cnt counts down to 1
// ST_DONE | done pulse for one cycle with Q/R valid, then back to IDLE
import paquete_divisor::*;

module divisor_restador_4bit #(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  estado_t          state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             borrow;

  paso_division #(.WIDTH(WIDTH)) u_paso (
    .rem      (rem_q),
    .quo      (quo_q),
    .B        (b_q),
    .rem_next (rem_next),
    .quo_next (quo_next),
    .borrow   (borrow)
  );

  // FSM, iteration counter and result registers; outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (B == '0) begin
              Q        <= '1;
              R        <= A;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              b_q      <= B;
              rem_q    <= '0;
              quo_q    <= A;
              cnt      <= CNT_W'(WIDTH);
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            // Final quotient bit taken directly from this step's borrow.
            Q     <= {quo_next[WIDTH-1:1], ~borrow};
            R     <= rem_next[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_restador_4bit.sv
// Scoreboard bench for divisor_restador_4bit: the driver pushes the arithmetic
// expectation per accepted start, the monitor pops and checks on each done pulse.
`timescale 1ns/1ps

module tb_divisor_restador_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, div_zero;
  logic [W-1:0] Q, R;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
    int           lat;
    longint       t_acc;
  } exp_t;

  exp_t sb[$];

  divisor_restador_4bit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Q        (Q),
    .R        (R),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per done pulse and check result, flags and timing.
  always @(negedge clk) begin
    exp_t e;
    if (!busy && !done) busy_cnt = 0;
    if (busy) busy_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("Q", int'(Q), int'(e.q));
        chk("R", int'(R), int'(e.r));
        chk("div_zero", int'(div_zero), int'(e.dz));
        chk("busy_with_done", int'(busy), 0);
        chk("latency", int'(($time - e.t_acc - 5) / 10), e.lat);
        chk("busy_cycles", busy_cnt, e.lat);
        if (e.b != 0) begin
          chk("invariant_qbr", int'(Q) * int'(e.b) + int'(R), int'(e.a));
          chk("invariant_r_lt_b", int'(R < e.b), 1);
        end
      end
      busy_cnt = 0;
    end
  end

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
    exp_t e;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    e.a = a; e.b = b; e.t_acc = $time;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 0;
    end else begin
      e.q = W'(a / b); e.r = W'(a % b); e.dz = 1'b0; e.lat = W;
    end
    sb.push_back(e);
    #1 start = 1'b0;
    if (glitch) begin
      @(negedge clk);
      @(negedge clk);
      A = 4'd1; B = 4'd1; start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    do_div(4'd13, 4'd4, 0);
    do_div(4'd15, 4'd1, 0);
    do_div(4'd3, 4'd9, 0);
    do_div(4'd0, 4'd5, 0);
    do_div(4'd7, 4'd0, 0);
    do_div(4'd9, 4'd3, 0);

    // start pulses during CALC must be ignored
    do_div(4'd14, 4'd3, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_Q", int'(Q), 4);
    chk("hold_R", int'(R), 2);

    // reset during the second CALC cycle aborts without a done pulse
    @(negedge clk);
    A = 4'd12; B = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_Q", int'(Q), 0);
    chk("midrst_R", int'(R), 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    do_div(4'd12, 4'd5, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        do_div(W'(a), W'(b), 0);

    repeat (40) do_div(W'($urandom_range(15, 0)), W'($urandom_range(15, 0)), 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
